// File: rtl/rf_wb_arbiter_if.sv
// Bundle of writeback-arbiter handshake, issue-check and register-file write signals.
// The slave modport is the arbiter's view; the master modport is the surrounding pipeline.
`timescale 1ns/1ps
interface rf_wb_arbiter_if #(
    parameter int XLEN = 32,
    parameter int NREG = 32
);
    // ALU writeback requester
    logic            a_valid_i;
    logic [4:0]      a_rd_i;
    logic [XLEN-1:0] a_wd_i;
    logic            a_ready_o;

    // Load-unit writeback requester
    logic            b_valid_i;
    logic [4:0]      b_rd_i;
    logic [XLEN-1:0] b_wd_i;
    logic            b_ready_o;

    // Decode issue hazard check
    logic            issue_valid_i;
    logic [4:0]      issue_rs1_i;
    logic [4:0]      issue_rs2_i;
    logic [4:0]      issue_rd_i;
    logic            issue_we_i;
    logic            stall_o;

    // Registered register-file write port and scoreboard view
    logic            regwrite_o;
    logic [4:0]      rd_o;
    logic [XLEN-1:0] wd_o;
    logic [NREG-1:0] busy_o;

    modport slave (
        input  a_valid_i, a_rd_i, a_wd_i,
        output a_ready_o,
        input  b_valid_i, b_rd_i, b_wd_i,
        output b_ready_o,
        input  issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_we_i,
        output stall_o,
        output regwrite_o, rd_o, wd_o, busy_o
    );

    modport master (
        output a_valid_i, a_rd_i, a_wd_i,
        input  a_ready_o,
        output b_valid_i, b_rd_i, b_wd_i,
        input  b_ready_o,
        output issue_valid_i, issue_rs1_i, issue_rs2_i, issue_rd_i, issue_we_i,
        input  stall_o,
        input  regwrite_o, rd_o, wd_o, busy_o
    );
endinterface

// File: rtl/rf_wb_arbiter.sv
// Two-requester round-robin writeback arbiter with a registered register-file
// write port and a busy-bit scoreboard that blocks hazardous issue.
`timescale 1ns/1ps
module rf_wb_arbiter #(
    parameter int XLEN = 32,
    parameter int NREG = 32
) (
    input  logic            clk_i,
    input  logic            reset_i,
    rf_wb_arbiter_if.slave  bus
);

    // Last-grant pointer values; reset points at B so A wins the first contention.
    localparam logic [0:0] PTR_A = 1'b0;
    localparam logic [0:0] PTR_B = 1'b1;

    logic [0:0]      r_lastGrant;
    logic            r_regWrite;
    logic [4:0]      r_rd;
    logic [XLEN-1:0] r_wd;
    logic [NREG-1:0] r_busy;

    logic            w_grantA;
    logic            w_grantB;
    logic            w_xfer;
    logic [4:0]      w_wbRd;
    logic [XLEN-1:0] w_wbWd;
    logic            w_stall;
    logic            w_issueSet;
    logic [NREG-1:0] w_busyNext;

    // Range-safe scoreboard lookup; index 0 and indices beyond NREG are never busy.
    function automatic logic busyAt(input logic [NREG-1:0] vec, input logic [4:0] idx);
        logic hit;
        hit = 1'b0;
        for (int i = 1; i < NREG; i++) begin
            if (idx == 5'(i)) begin
                hit = vec[i];
            end
        end
        return hit;
    endfunction

    // Grant selection: a lone requester wins outright, contention goes to the side not granted last.
    always_comb begin
        w_grantA = 1'b0;
        w_grantB = 1'b0;
        if (!reset_i) begin
            if (bus.a_valid_i && bus.b_valid_i) begin
                if (r_lastGrant == PTR_B) begin
                    w_grantA = 1'b1;
                end else begin
                    w_grantB = 1'b1;
                end
            end else begin
                w_grantA = bus.a_valid_i;
                w_grantB = bus.b_valid_i;
            end
        end
    end

    assign w_xfer = w_grantA | w_grantB;
    assign w_wbRd = w_grantA ? bus.a_rd_i : bus.b_rd_i;
    assign w_wbWd = w_grantA ? bus.a_wd_i : bus.b_wd_i;

    // Hazard check uses the registered scoreboard only, so a writeback this cycle cannot unblock issue early.
    always_comb begin
        w_stall = 1'b0;
        if (!reset_i && bus.issue_valid_i) begin
            w_stall = busyAt(r_busy, bus.issue_rs1_i) ||
                      busyAt(r_busy, bus.issue_rs2_i) ||
                      (bus.issue_we_i && busyAt(r_busy, bus.issue_rd_i));
        end
    end

    assign w_issueSet = !reset_i && bus.issue_valid_i && !w_stall &&
                        bus.issue_we_i && (bus.issue_rd_i != 5'd0);

    // Next scoreboard: writeback clears first, then issue sets, so a same-index set wins.
    always_comb begin
        w_busyNext = r_busy;
        for (int i = 1; i < NREG; i++) begin
            if (w_xfer && (w_wbRd == 5'(i))) begin
                w_busyNext[i] = 1'b0;
            end
            if (w_issueSet && (bus.issue_rd_i == 5'(i))) begin
                w_busyNext[i] = 1'b1;
            end
        end
        w_busyNext[0] = 1'b0;
    end

    // Pointer advances only when a transfer is actually accepted.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_lastGrant <= PTR_B;
        end else if (w_xfer) begin
            r_lastGrant <= w_grantB ? PTR_B : PTR_A;
        end
    end

    // Registered write port: pulse on accepted writes to rd!=0, zero for rd=0, hold data when idle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_regWrite <= 1'b0;
            r_rd       <= 5'd0;
            r_wd       <= '0;
        end else if (w_xfer) begin
            if (w_wbRd != 5'd0) begin
                r_regWrite <= 1'b1;
                r_rd       <= w_wbRd;
                r_wd       <= w_wbWd;
            end else begin
                r_regWrite <= 1'b0;
                r_rd       <= 5'd0;
                r_wd       <= '0;
            end
        end else begin
            r_regWrite <= 1'b0;
        end
    end

    // Scoreboard register.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_busy <= '0;
        end else begin
            r_busy <= w_busyNext;
        end
    end

    assign bus.a_ready_o  = w_grantA;
    assign bus.b_ready_o  = w_grantB;
    assign bus.stall_o    = w_stall;
    assign bus.regwrite_o = r_regWrite;
    assign bus.rd_o       = r_rd;
    assign bus.wd_o       = r_wd;
    assign bus.busy_o     = r_busy;

endmodule
